// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
// Imported by the picker and the arbiter top.
package rr_arbiter_8_pkg;

    localparam int NUM_REQ      = 8;
    localparam int IDX_W        = 3;
    localparam int DEF_MAX_HOLD = 16;
    localparam int DEF_CNT_W    = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_8_pick8.sv
// Combinational rotate-priority-rotate picker: finds the first set request
// after ptr (wrapping 7->0), optionally ignoring one masked requester.
module rr_pick8
    import rr_arbiter_8_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [IDX_W-1:0]   mask_idx,
    input  logic               mask_en,
    output logic [IDX_W-1:0]   win_idx,
    output logic               win_vld
);

    logic [NUM_REQ-1:0]   req_m;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W:0]       shamt;
    logic [IDX_W-1:0]     off;

    always_comb begin
        req_m = req;
        if (mask_en) begin
            req_m[mask_idx] = 1'b0;
        end
        // Rotate so that bit 0 of rot corresponds to requester ptr+1.
        shamt   = {1'b0, ptr} + {{IDX_W{1'b0}}, 1'b1};
        req_dbl = {req_m, req_m} >> shamt;
        rot     = req_dbl[NUM_REQ-1:0];

        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end

        win_vld = |rot;
        win_idx = ptr + IDX_W'(1) + off;
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters sharing one decoded resource, with
// grant hold while requested and an optional maximum hold time.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   hold_q, hold_d;

    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic               timeout;

    // While granted, the owner never competes in re-arbitration; on release
    // its request bit is already low, on timeout it falls back below.
    rr_pick8 u_pick (
        .req      (req),
        .ptr      (last_q),
        .mask_idx (gnt_idx_q),
        .mask_en  (state_q == ST_GRANT),
        .win_idx  (win_idx),
        .win_vld  (win_vld)
    );

    assign timeout = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        last_d    = last_q;
        hold_d    = hold_q;

        case (state_q)
            ST_IDLE: begin
                if (en && win_vld) begin
                    state_d   = ST_GRANT;
                    gnt_idx_d = win_idx;
                    gnt_vld_d = 1'b1;
                    last_d    = win_idx;
                    hold_d    = '0;
                end
            end
            ST_GRANT: begin
                if (!en) begin
                    state_d   = ST_IDLE;
                    gnt_vld_d = 1'b0;
                end else if (!req[gnt_idx_q]) begin
                    if (win_vld) begin
                        gnt_idx_d = win_idx;
                        last_d    = win_idx;
                        hold_d    = '0;
                    end else begin
                        state_d   = ST_IDLE;
                        gnt_vld_d = 1'b0;
                    end
                end else if (timeout) begin
                    // Sole requester keeps the grant; only its hold restarts.
                    if (win_vld) begin
                        gnt_idx_d = win_idx;
                        last_d    = win_idx;
                    end
                    hold_d = '0;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_vld_q) begin
            gnt[gnt_idx_q] = 1'b1;
        end
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign busy    = (state_q == ST_GRANT);

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 built with MAX_HOLD=4: reset, rotation,
// release handoff, wrap, sole-owner re-grant, timeout handoff and enable drop.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic [7:0] gnt;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .gnt     (gnt),
        .busy    (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic vld, input logic [2:0] idx);
        logic [7:0] e;
        e = 8'h00;
        if (vld) e[idx] = 1'b1;
        check({tag, "_vld"}, 32'(gnt_vld), 32'(vld));
        check({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, "_gnt"}, 32'(gnt), 32'(e));
        check({tag, "_busy"}, 32'(busy), 32'(vld));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        step();
        step();
        check_grant("reset", 1'b0, 3'd0);
        rst = 1'b0;

        // First grant, then async reset in the middle of the cycle
        en  = 1'b1;
        req = 8'h01;
        step();
        check_grant("first", 1'b1, 3'd0);
        check("no_x", 32'($isunknown({gnt_idx, gnt_vld, gnt, busy})), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_grant("async_rst", 1'b0, 3'd0);
        step();
        rst = 1'b0;

        // All requesting: 4 cycles each, 0..7 then 0 again, no gaps
        req = 8'hFF;
        step();
        for (int o = 0; o <= 8; o++) begin
            for (int c = 0; c < 4; c++) begin
                check_grant($sformatf("rot_o%0d_c%0d", o, c), 1'b1, 3'(o % 8));
                step();
            end
        end
        check_grant("rot_after", 1'b1, 3'd1);

        // Enable drop keeps index, then resumes at last+1
        en = 1'b0;
        step();
        check_grant("en_off", 1'b0, 3'd1);
        en = 1'b1;
        step();
        check_grant("en_on", 1'b1, 3'd2);

        // Release handoff to 5, then 5 -> 0, then to idle
        req = 8'h20;
        step();
        check_grant("rel_to5", 1'b1, 3'd5);
        req = 8'h21;
        step();
        check_grant("hold5", 1'b1, 3'd5);
        req = 8'h01;
        step();
        check_grant("rel_to0", 1'b1, 3'd0);
        req = 8'h00;
        step();
        check_grant("rel_idle", 1'b0, 3'd0);

        // Wrap: last=6, requests 6 and 0 -> 0 wins
        req = 8'h40;
        step();
        check_grant("own6", 1'b1, 3'd6);
        req = 8'h00;
        step();
        check_grant("idle6", 1'b0, 3'd6);
        req = 8'h41;
        step();
        check_grant("wrap0", 1'b1, 3'd0);

        // Sole requester 3 is re-granted across timeouts without a gap
        req = 8'h08;
        step();
        for (int i = 0; i < 10; i++) begin
            check_grant($sformatf("sole3_%0d", i), 1'b1, 3'd3);
            step();
        end

        // Hold counter now at 2; one more cycle, then timeout hands to 7
        req = 8'h88;
        step();
        check_grant("to_hold3", 1'b1, 3'd3);
        step();
        check_grant("to_7", 1'b1, 3'd7);

        check("no_x_end", 32'($isunknown({gnt_idx, gnt_vld, gnt, busy})), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one 3-to-8 decoded resource (select bus, chip-select fan-out) among 8 requesters.
- Picks a requester fairly, holds the grant while that requester keeps requesting, and enforces a maximum hold time.
- Drives a registered 3-bit grant index, a valid/enable, and the matching one-hot grant vector.
- Sits between requester logic and the decoded select lines.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 disables the timeout.
- CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global arbitration enable.
- req  input  8  request vector, bit i = requester i.
- gnt_idx  output  3  registered index of the current owner.
- gnt_vld  output  1  registered; high while a grant is held.
- gnt  output  8  one-hot grant = decode(gnt_idx) gated by gnt_vld; all zero when gnt_vld=0.
- busy  output  1  high in GRANT state; equals gnt_vld.

Behaviour:
- Reset (async, active-high) forces: state=IDLE, gnt_idx=0, gnt_vld=0, gnt=0, busy=0, hold_cnt=0, last=7 (so requester 0 has first priority).
- Priority rule: search req starting at (last+1) mod 8, ascending, wrapping 7->0. The first set bit wins.
- IDLE:
  - If en=1 and req!=0, register the winner: next cycle gnt_idx=winner, gnt_vld=1, last=winner, hold_cnt=0, state=GRANT.
  - Latency from req to gnt is 1 clock.
- GRANT, each cycle, in priority order:
  1. en=0: next cycle gnt_vld=0, state=IDLE. last is kept; gnt_idx holds its value.
  2. req[gnt_idx]=0 (release): re-arbitrate this cycle on req with pointer=last.
     - If a winner exists, grant it next cycle with no idle gap and hold_cnt=0.
     - Otherwise gnt_vld=0 and state=IDLE.
  3. Timeout (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and req[gnt_idx]=1): re-arbitrate with the current owner at lowest priority.
     - If another requester is pending, it wins.
     - If the owner is the only requester, it is re-granted with hold_cnt=0. gnt_vld stays high with no gap.
  4. Otherwise hold_cnt increments; outputs are unchanged.
- hold_cnt saturates at MAX_HOLD-1 and never wraps. With MAX_HOLD=0 it stays at 0.
- Requests from the current owner while it is granted are ignored for arbitration; they only extend the hold.
- A request arriving in the same cycle as a release is eligible in that release arbitration.
- gnt_idx never changes while gnt_vld=1 except at a handoff edge.
- gnt is exactly one-hot or zero, and is combinational from registers only (no req-to-gnt combinational path).
- X on req is never propagated: bits are treated as sampled, and the bench checks that no X appears on outputs after reset.
- Reset mid-grant drops gnt_vld immediately (async) and restores priority to requester 0.

Decomposition:
- Shared package/header:
  - state encoding constants ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NUM_REQ=8 and IDX_W=3.
  - the default MAX_HOLD.
- Sub-module rr_pick8:
  - Purely combinational rotate-priority-rotate picker.
  - Inputs: req[7:0], ptr[2:0], mask_idx[2:0], mask_en.
  - Outputs: win_idx[2:0], win_vld.
  - Used for both the IDLE and GRANT re-arbitration paths.
- The one-hot gnt decode stays inline in rr_arbiter_8.

Test Plan:
- Reset then req=8'h01 with en=1 -> after 1 clk: gnt_idx=0, gnt_vld=1, gnt=8'h01. Assert rst mid-grant -> gnt=8'h00 immediately.
- req=8'hFF held, MAX_HOLD=4 -> owners rotate 0,1,2,...,7,0, each granted exactly 4 cycles, with no gnt_vld gap at handoffs.
- Owner 5 granted, req=8'h21 (bits 5 and 0), then drop bit 5 -> next cycle gnt_idx=0, gnt=8'h01. Then drop bit 0 -> gnt_vld=0 and the arbiter returns to IDLE.
- Wrap check: last=6, req=8'h41 (bits 6 and 0) after release -> requester 0 wins, because the search starts at 7 and wraps to 0.
- Sole requester 3 held for 10 cycles with MAX_HOLD=4 -> gnt_vld stays 1 and gnt_idx stays 3 throughout; hold_cnt resets at cycles 4 and 8.
- en drops during grant -> next cycle gnt_vld=0, gnt=0. en returns with req=8'hFF -> grant goes to (last+1) mod 8.
